// File: rtl/usb_rx_bit_recovery_if.sv
// Line-side and decoded-bit signals of the USB receive bit recovery block.
// The master side drives the synchronized D+/D- pair and consumes the decoded
// stream; the slave side is the recovery logic itself.
interface usb_rx_bit_recovery_if;
    logic d_plus;     // synchronized D+ (idle J = 1)
    logic d_minus;    // synchronized D- (idle J = 0)
    logic bit_out;    // decoded data bit, valid with bit_valid
    logic bit_valid;  // one-cycle strobe per decoded non-stuffed bit
    logic eop;        // one-cycle pulse on end-of-packet
    logic stuff_err;  // one-cycle pulse: stuffed bit was not a 0
    logic line_err;   // one-cycle pulse: isolated single-bit SE0
    logic busy;       // high while receiving

    modport master (
        output d_plus, d_minus,
        input  bit_out, bit_valid, eop, stuff_err, line_err, busy
    );

    modport slave (
        input  d_plus, d_minus,
        output bit_out, bit_valid, eop, stuff_err, line_err, busy
    );
endinterface

// File: rtl/usb_rx_bit_recovery.sv
// USB receive bit recovery: oversamples the synchronized differential pair,
// resynchronizes the bit timer on every D+ transition, NRZI-decodes, strips
// stuffed bits, detects SE0 end-of-packet and flags line errors. All outputs
// are registered, so a sample taken in cycle t is visible in cycle t+1.
module usb_rx_bit_recovery #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_POINT = 3,
    parameter int STUFF_LIMIT  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    usb_rx_bit_recovery_if.slave  bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int OW = $clog2(STUFF_LIMIT + 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t        state;
    logic          prev_dp;
    logic          last_bit;
    logic [CW-1:0] cnt;
    logic [OW-1:0] ones;
    logic [1:0]    se0_cnt;

    logic bit_out_r, bit_valid_r, eop_r, stuff_err_r, line_err_r, busy_r;

    logic line_edge, se0, sample, dec;

    // Any D+ change marks a bit boundary; an edge always wins over a sample
    // in the same cycle so a late edge never produces a duplicate bit.
    assign line_edge = (bus.d_plus != prev_dp);
    assign se0       = !bus.d_plus && !bus.d_minus;
    assign sample    = (state == ACTIVE) && !line_edge && (cnt == CW'(SAMPLE_POINT));
    // NRZI: no change in level decodes as 1, a change as 0.
    assign dec       = (bus.d_plus == last_bit);

    // Bit timer, NRZI decode, destuffing and EOP/error detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            prev_dp     <= 1'b1;
            last_bit    <= 1'b1;
            cnt         <= '0;
            ones        <= '0;
            se0_cnt     <= '0;
            bit_out_r   <= 1'b1;
            bit_valid_r <= 1'b0;
            eop_r       <= 1'b0;
            stuff_err_r <= 1'b0;
            line_err_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            prev_dp     <= bus.d_plus;
            bit_valid_r <= 1'b0;
            eop_r       <= 1'b0;
            stuff_err_r <= 1'b0;
            line_err_r  <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    // Only a J->K transition starts reception; the edge cycle
                    // counts as 0, so the timer restarts at 1.
                    if (line_edge && !bus.d_plus && bus.d_minus) begin
                        state  <= ACTIVE;
                        busy_r <= 1'b1;
                        cnt    <= CW'(1);
                    end
                end

                ACTIVE: begin
                    if (line_edge)
                        cnt <= CW'(1);
                    else if (cnt == CW'(CLKS_PER_BIT - 1))
                        cnt <= '0;
                    else
                        cnt <= cnt + 1'b1;

                    if (sample) begin
                        if (se0) begin
                            // Two consecutive SE0 bit times end the packet.
                            if (se0_cnt == 2'd1) begin
                                eop_r    <= 1'b1;
                                busy_r   <= 1'b0;
                                state    <= IDLE;
                                last_bit <= 1'b1;
                                ones     <= '0;
                                se0_cnt  <= '0;
                                cnt      <= '0;
                            end else begin
                                se0_cnt <= se0_cnt + 1'b1;
                            end
                        end else begin
                            // A lone SE0 bit is reported, then this bit is
                            // decoded against the level seen before the SE0.
                            if (se0_cnt == 2'd1)
                                line_err_r <= 1'b1;
                            se0_cnt  <= '0;
                            last_bit <= bus.d_plus;
                            if (ones == OW'(STUFF_LIMIT)) begin
                                ones        <= '0;
                                stuff_err_r <= dec;
                            end else begin
                                bit_valid_r <= 1'b1;
                                bit_out_r   <= dec;
                                ones        <= dec ? ones + 1'b1 : '0;
                            end
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.bit_out   = bit_out_r;
    assign bus.bit_valid = bit_valid_r;
    assign bus.eop       = eop_r;
    assign bus.stuff_err = stuff_err_r;
    assign bus.line_err  = line_err_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_usb_rx_bit_recovery.sv
// Directed bench for usb_rx_bit_recovery: an NRZI/stuffing line encoder pushes
// expected decoded bits into a queue; a negedge monitor pops and compares them
// on every strobe and counts pulse events for the directed checkpoints.
module tb_usb_rx_bit_recovery;
    localparam int CPB = 8;
    localparam int SP  = 3;
    localparam int SL  = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    usb_rx_bit_recovery_if bus();

    usb_rx_bit_recovery #(
        .CLKS_PER_BIT (CPB),
        .SAMPLE_POINT (SP),
        .STUFF_LIMIT  (SL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit   exp_q[$];
    int   strobe_t[$];
    int   n_strobe = 0, n_eop = 0, n_serr = 0, n_lerr = 0;
    int   eop_t = 0, busy_rise_t = 0;
    logic busy_q = 1'b0;

    logic lvl;       // encoder line level, 1 = J
    int   tx_ones;   // encoder run of consecutive 1s
    bit   stuff_en;  // encoder inserts stuffed bits when set

    // Cycle counter: number of rising edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Monitor: scoreboard pop on each strobe, event counting and pulse rules.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.bit_valid) begin
                    n_strobe++;
                    strobe_t.push_back(cyc);
                    check("strobe_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0)
                        check("bit_value", bus.bit_out, exp_q.pop_front());
                end
                if (bus.eop) begin
                    n_eop++;
                    eop_t = cyc;
                    check("eop_busy_low", bus.busy, 0);
                    check("eop_no_strobe", bus.bit_valid, 0);
                end
                if (bus.stuff_err) begin
                    n_serr++;
                    check("stuff_err_no_strobe", bus.bit_valid, 0);
                end
                if (bus.line_err)
                    n_lerr++;
                if (bus.busy && !busy_q)
                    busy_rise_t = cyc;
                busy_q = bus.busy;
            end
        end
    end

    task automatic drive(input int n);
        repeat (n) begin
            bus.d_plus  = lvl;
            bus.d_minus = !lvl;
            @(negedge clk);
        end
    endtask

    task automatic drive_se0(input int n);
        repeat (n) begin
            bus.d_plus  = 1'b0;
            bus.d_minus = 1'b0;
            @(negedge clk);
        end
    endtask

    // NRZI-encode one data bit, inserting a stuffed 0 after SL ones.
    task automatic tx_bit(input bit b, input int per);
        exp_q.push_back(b);
        if (!b) lvl = !lvl;
        drive(per);
        tx_ones = b ? tx_ones + 1 : 0;
        if (tx_ones == SL && stuff_en) begin
            lvl = !lvl;
            drive(per);
            tx_ones = 0;
        end
    endtask

    task automatic tx_sync(input int per);
        for (int i = 0; i < 8; i++) tx_bit(i == 7, per);
    endtask

    task automatic tx_eop();
        drive_se0(2 * CPB);
        lvl     = 1'b1;
        tx_ones = 0;
        drive(CPB);
    endtask

    initial begin
        int t0, c, s0, e0, l0, p0;
        lvl = 1'b1; tx_ones = 0; stuff_en = 1'b1;
        bus.d_plus = 1'b1; bus.d_minus = 1'b0;
        rst = 1'b1;

        // Reset values
        @(negedge clk); @(negedge clk); #1;
        check("rst_bit_out", bus.bit_out, 1);
        check("rst_bit_valid", bus.bit_valid, 0);
        check("rst_eop", bus.eop, 0);
        check("rst_stuff_err", bus.stuff_err, 0);
        check("rst_line_err", bus.line_err, 0);
        check("rst_busy", bus.busy, 0);
        rst = 1'b0;

        // SE0 and a rising D+ edge while idle are ignored
        drive_se0(3);
        drive(6); #1;
        check("idle_busy", bus.busy, 0);
        check("idle_strobes", n_strobe, 0);

        // SYNC timing: busy at t0+1, first strobe at t0+4, 8-cycle spacing
        strobe_t.delete();
        t0 = cyc;
        tx_sync(CPB); #1;
        check("sync_busy_rise", busy_rise_t - t0, 1);
        check("sync_strobes", strobe_t.size(), 8);
        if (strobe_t.size() > 0)
            check("sync_first_strobe", strobe_t[0] - t0, SP + 1);
        for (int i = 1; i < strobe_t.size(); i++)
            check("sync_spacing", strobe_t[i] - strobe_t[i-1], CPB);

        // Valid stuffing: six 1s, stuffed 0 dropped, then another 1
        s0 = n_strobe; e0 = n_serr;
        tx_bit(0, CPB);
        repeat (6) tx_bit(1, CPB);
        tx_bit(1, CPB); #1;
        check("stuff_strobes", n_strobe - s0, 8);
        check("stuff_no_err", n_serr - e0, 0);

        // Stuff violation: the bit after six 1s is another 1
        s0 = n_strobe; e0 = n_serr;
        stuff_en = 1'b0;
        tx_bit(0, CPB);
        repeat (6) tx_bit(1, CPB);
        drive(CPB);
        tx_ones = 0; stuff_en = 1'b1;
        tx_bit(0, CPB); #1;
        check("viol_strobes", n_strobe - s0, 8);
        check("viol_stuff_err", n_serr - e0, 1);
        check("viol_queue_empty", exp_q.size(), 0);

        // EOP: second SE0 sample at boundary+11, pulse visible one cycle later
        s0 = n_strobe; e0 = n_eop;
        c = cyc;
        tx_eop(); #1;
        check("eop_count", n_eop - e0, 1);
        check("eop_timing", eop_t - c, 2 * CPB - (CPB - SP) + 1);
        check("eop_busy_after", bus.busy, 0);
        check("eop_no_bits", n_strobe - s0, 0);

        // Jitter: 16 bits at 9-clock period then 16 at 7-clock period
        s0 = n_strobe; e0 = n_eop;
        tx_sync(CPB);
        for (int i = 0; i < 16; i++) tx_bit(i % 2 == 1, CPB + 1);
        for (int i = 0; i < 16; i++) tx_bit(i % 2 == 1, CPB - 1);
        #1;
        check("jitter_strobes", n_strobe - s0, 40);
        check("jitter_queue_empty", exp_q.size(), 0);
        tx_eop(); #1;
        check("jitter_eop", n_eop - e0, 1);

        // Single-bit SE0 glitch mid-packet
        s0 = n_strobe; l0 = n_lerr; p0 = n_eop;
        tx_sync(CPB);
        tx_bit(0, CPB);
        tx_bit(1, CPB);
        drive_se0(CPB);
        tx_bit(0, CPB);
        tx_bit(1, CPB);
        tx_bit(0, CPB); #1;
        check("glitch_line_err", n_lerr - l0, 1);
        check("glitch_strobes", n_strobe - s0, 13);
        check("glitch_no_eop", n_eop - p0, 0);
        check("glitch_busy", bus.busy, 1);

        // Reset mid-bit, before the sample point of the partial bit
        lvl = !lvl;
        drive(2);
        rst = 1'b1;
        @(negedge clk); #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_bit_out", bus.bit_out, 1);
        check("midrst_bit_valid", bus.bit_valid, 0);
        check("midrst_pulses", {bus.eop, bus.stuff_err, bus.line_err}, 0);
        rst = 1'b0;
        lvl = 1'b1;
        s0 = n_strobe;
        drive(3 * CPB); #1;
        check("post_rst_quiet", n_strobe - s0, 0);
        check("post_rst_busy", bus.busy, 0);

        // A fresh J->K edge reactivates reception
        s0 = n_strobe;
        tx_sync(CPB); #1;
        check("react_strobes", n_strobe - s0, 8);
        check("react_busy", bus.busy, 1);
        tx_eop(); #1;
        check("final_busy", bus.busy, 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/usb_rx_bit_recovery.md
Name: usb_rx_bit_recovery

Overview:
- Consumes the synchronized USB differential pair, d_plus and d_minus, directly downstream of the input synchronizers.
- Recovers bit timing by oversampling and resynchronizing on every d_plus transition.
- NRZI-decodes the line, removes stuffed bits, detects SE0 end-of-packet and flags line errors.
- Feeds decoded bits, with a one-cycle strobe, to the receive shift register and the receive control unit.

Parameters:
CLKS_PER_BIT, 8, system clocks per USB bit period (>=4)
SAMPLE_POINT, 3, count value at which the line is sampled (1..CLKS_PER_BIT-2)
STUFF_LIMIT, 6, consecutive decoded 1s after which a stuffed 0 is expected

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
d_plus  input  1  synchronized D+ (idle J = 1)
d_minus  input  1  synchronized D- (idle J = 0)
bit_out  output  1  decoded data bit, valid when bit_valid=1
bit_valid  output  1  one-cycle strobe per decoded non-stuffed bit
eop  output  1  one-cycle pulse on end-of-packet detection
stuff_err  output  1  one-cycle pulse: stuffed bit was not a 0
line_err  output  1  one-cycle pulse: isolated single-bit SE0
busy  output  1  high while in ACTIVE

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset, with rst sampled high at a clk edge:
  - state=IDLE, prev_dp=1, last_bit=1, cnt=0, ones=0, se0_cnt=0.
  - bit_out=1; bit_valid, eop, stuff_err, line_err and busy all 0.
  - rst overrides everything, including mid-packet; the next cycle shows reset values.
- Edge detection: edge = (d_plus != prev_dp); prev_dp <= d_plus every cycle.
- IDLE:
  - cnt held at 0.
  - Transition to ACTIVE only on an edge in the same cycle as d_plus=0 and d_minus=1 (J->K). cnt <= 1.
  - All other edges and SE0 are ignored.
- ACTIVE, bit timer:
  - On an edge: cnt <= 1; the edge cycle counts as 0.
  - Otherwise: cnt <= (cnt==CLKS_PER_BIT-1) ? 0 : cnt+1.
  - A sample occurs when cnt==SAMPLE_POINT and there is no edge that cycle. An edge wins over a sample in the same cycle; no sample is taken.
- Sample processing, where SE0 = (d_plus==0 && d_minus==0):
  - SE0 sample: se0_cnt++. No bit_valid. last_bit and ones are unchanged.
    - If se0_cnt reaches 2: eop pulse, then return to IDLE with last_bit=1, ones=0, se0_cnt=0, cnt=0.
  - Non-SE0 sample with se0_cnt==1: line_err pulse and se0_cnt <= 0. This bit is then decoded normally.
  - Non-SE0 sample: decoded d = (d_plus == last_bit); last_bit <= d_plus.
    - If ones==STUFF_LIMIT: stuffed bit. No bit_valid; ones <= 0. If d==1, stuff_err pulse. Reception continues in ACTIVE.
    - Else: bit_valid=1 and bit_out=d. ones <= d ? ones+1 : 0.
- Latency: all outputs are registered.
  - A sample taken in cycle t produces bit_valid, bit_out, eop, stuff_err or line_err in cycle t+1.
  - The first bit after the J->K edge at cycle t0 strobes at t0+SAMPLE_POINT+1.
- Pulses last exactly one cycle. bit_out holds its last value between strobes.
- busy=1 in ACTIVE; it drops in the same cycle eop is asserted.
- Simultaneous events:
  - eop and stuff_err cannot coincide.
  - line_err and bit_valid may coincide.
- Counter widths: cnt is clog2(CLKS_PER_BIT) bits; ones is clog2(STUFF_LIMIT+1) bits; no overflow is possible.

Test Plan:
- Reset: hold rst=1 for 2 cycles with d_plus=1, d_minus=0 -> bit_out=1, all other outputs 0, busy=0. Edges with d_plus=1, d_minus=0 while IDLE -> busy stays 0.
- SYNC: drive KJKJKJKK, 8 clocks per level, first K edge at cycle t0 -> busy=1 at t0+1. First bit_valid at t0+4. Eight strobes spaced 8 cycles apart, bits 0,0,0,0,0,0,0,1.
- Stuffing: after SYNC, hold the line for 6 bit times, then toggle for one bit, then hold -> six strobes of 1, no strobe for the stuffed bit, following strobe=1, stuff_err=0. Repeat without the toggle -> stuff_err pulses once, no strobe for that bit.
- EOP: after data, drive SE0 for 16 clocks, then J -> eop pulses one cycle at the second SE0 sample+1, busy=0 the same cycle. No bit_valid during SE0. A new J->K edge reactivates the block.
- Jitter/resync: stream 32 alternating-pattern bits with a 9-clock period, then 7-clock periods -> exactly 32 strobes with correct values, no duplicated or missed bits.
- Glitch/reset: a one-bit SE0 mid-packet -> line_err pulse, packet continues. Asserting rst mid-byte -> next cycle busy=0 with all reset values, and no strobes until the next J->K edge.
